// File: rtl/vram_arbiter.sv
// Arbitrates the 2 KB nametable VRAM between PPU render fetches and CPU PPUDATA
// accesses, applying cartridge nametable mirroring to form bank and address.
module vram_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        vram_arb_clk_in,
    input  logic        vram_arb_reset_in,
    input  logic [1:0]  mirror_mode_in,
    input  logic        ppu_req_in,
    input  logic [13:0] ppu_addr_in,
    output logic [7:0]  ppu_data_out,
    output logic        ppu_valid_out,
    output logic        ppu_miss_out,
    input  logic        cpu_req_in,
    input  logic        cpu_we_in,
    input  logic [13:0] cpu_addr_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_ack_out,
    output logic        ram_enable_out,
    output logic        ram_read_out,
    output logic        ram_write_out,
    output logic        ram_bank_out,
    output logic [9:0]  ram_address_out,
    output logic [7:0]  ram_data_out,
    input  logic [7:0]  ram_data_in,
    output logic [15:0] arb_debug_out
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic          busy_r;
    logic [SW-1:0] starve_cnt_r;
    logic [7:0]    miss_cnt_r;
    logic [7:0]    grant_cnt_r;

    logic          s1_valid_r;
    logic          s1_cpu_r;
    logic          s1_we_r;
    logic          s1_inr_r;
    logic          s2_rd_r;
    logic          s2_cpu_r;
    logic          s2_inr_r;

    logic          cpu_elig_s;
    logic          grant_ppu_s;
    logic          grant_cpu_s;
    logic          grant_s;
    logic          is_write_s;
    logic [13:0]   gaddr_s;
    logic          in_range_s;
    logic          bank_s;

    // Grant decision: PPU first unless the pending CPU request has starved long enough.
    always_comb begin
        cpu_elig_s  = cpu_req_in & ~busy_r;
        grant_ppu_s = 1'b0;
        grant_cpu_s = 1'b0;
        if (vram_arb_reset_in) begin
            grant_ppu_s = 1'b0;
            grant_cpu_s = 1'b0;
        end else if (ppu_req_in && (!cpu_elig_s || (starve_cnt_r < LIMIT))) begin
            grant_ppu_s = 1'b1;
        end else if (cpu_elig_s) begin
            grant_cpu_s = 1'b1;
        end else begin
            grant_ppu_s = 1'b0;
            grant_cpu_s = 1'b0;
        end
    end

    assign grant_s      = grant_ppu_s | grant_cpu_s;
    assign is_write_s   = grant_cpu_s & cpu_we_in;
    assign ppu_miss_out = grant_cpu_s & ppu_req_in;

    // Nametable window and mirroring decode of the granted address.
    always_comb begin
        gaddr_s    = grant_cpu_s ? cpu_addr_in : ppu_addr_in;
        in_range_s = (gaddr_s[13:12] == 2'b10) ||
                     ((gaddr_s[13:12] == 2'b11) && (gaddr_s[11:8] != 4'hF));
        case (mirror_mode_in)
            2'd0:    bank_s = gaddr_s[11];
            2'd1:    bank_s = gaddr_s[10];
            2'd2:    bank_s = 1'b0;
            2'd3:    bank_s = 1'b1;
            default: bank_s = 1'b0;
        endcase
    end

    // Issue stage: RAM strobes one cycle after grant, zeroed when nothing is issued.
    always_ff @(posedge vram_arb_clk_in) begin
        if (vram_arb_reset_in) begin
            s1_valid_r      <= 1'b0;
            s1_cpu_r        <= 1'b0;
            s1_we_r         <= 1'b0;
            s1_inr_r        <= 1'b0;
            ram_enable_out  <= 1'b0;
            ram_read_out    <= 1'b0;
            ram_write_out   <= 1'b0;
            ram_bank_out    <= 1'b0;
            ram_address_out <= 10'd0;
            ram_data_out    <= 8'h00;
        end else begin
            s1_valid_r      <= grant_s;
            s1_cpu_r        <= grant_cpu_s;
            s1_we_r         <= is_write_s;
            s1_inr_r        <= in_range_s;
            ram_enable_out  <= grant_s & in_range_s;
            ram_read_out    <= grant_s & in_range_s & ~is_write_s;
            ram_write_out   <= grant_s & in_range_s & is_write_s;
            ram_bank_out    <= grant_s & in_range_s & bank_s;
            ram_address_out <= (grant_s && in_range_s) ? gaddr_s[9:0] : 10'd0;
            ram_data_out    <= (is_write_s && in_range_s) ? cpu_wdata_in : 8'h00;
        end
    end

    // Wait stage: RAM q becomes valid while a read sits here.
    always_ff @(posedge vram_arb_clk_in) begin
        if (vram_arb_reset_in) begin
            s2_rd_r  <= 1'b0;
            s2_cpu_r <= 1'b0;
            s2_inr_r <= 1'b0;
        end else begin
            s2_rd_r  <= s1_valid_r & ~s1_we_r;
            s2_cpu_r <= s1_cpu_r;
            s2_inr_r <= s1_inr_r;
        end
    end

    // Completion stage: writes ack from the issue stage, reads from the wait stage.
    always_ff @(posedge vram_arb_clk_in) begin
        if (vram_arb_reset_in) begin
            ppu_valid_out <= 1'b0;
            ppu_data_out  <= 8'h00;
            cpu_ack_out   <= 1'b0;
            cpu_rdata_out <= 8'h00;
        end else begin
            ppu_valid_out <= s2_rd_r & ~s2_cpu_r;
            cpu_ack_out   <= (s2_rd_r & s2_cpu_r) | (s1_valid_r & s1_cpu_r & s1_we_r);
            if (s2_rd_r && !s2_cpu_r) begin
                ppu_data_out <= s2_inr_r ? ram_data_in : 8'h00;
            end else begin
                ppu_data_out <= ppu_data_out;
            end
            if (s2_rd_r && s2_cpu_r) begin
                cpu_rdata_out <= s2_inr_r ? ram_data_in : 8'h00;
            end else begin
                cpu_rdata_out <= cpu_rdata_out;
            end
        end
    end

    // CPU busy flag, starvation counter and debug counters.
    always_ff @(posedge vram_arb_clk_in) begin
        if (vram_arb_reset_in) begin
            busy_r       <= 1'b0;
            starve_cnt_r <= '0;
            miss_cnt_r   <= 8'h00;
            grant_cnt_r  <= 8'h00;
        end else begin
            if (grant_cpu_s) begin
                busy_r <= 1'b1;
            end else if (cpu_ack_out) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (grant_cpu_s) begin
                starve_cnt_r <= '0;
            end else if (cpu_elig_s && (starve_cnt_r < LIMIT)) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
            if (ppu_miss_out && (miss_cnt_r != 8'hFF)) begin
                miss_cnt_r <= miss_cnt_r + 8'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
            if (grant_cpu_s) begin
                grant_cnt_r <= grant_cnt_r + 8'd1;
            end else begin
                grant_cnt_r <= grant_cnt_r;
            end
        end
    end

    assign arb_debug_out = {miss_cnt_r, grant_cnt_r};

endmodule
